td_alu_sequencer: RTL and testbench

TD_ALU_SEQUENCER -- requirements
Module: td_alu_sequencer

---
 rtl/td_alu_sequencer_if.sv | 32 +++
 rtl/td_alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_td_alu_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/td_alu_sequencer_if.sv
// Request, ALU drive and response signals of the time-domain ALU sequencer.
interface td_alu_sequencer_if #(
    parameter int W = 4
);
    logic         req_valid_i;
    logic         req_ready_o;
    logic [2:0]   req_op_i;
    logic [W-1:0] req_a_i;
    logic [W-1:0] req_b_i;
    logic         alu_a_o;
    logic         alu_b_o;
    logic [2:0]   alu_op_o;
    logic         alu_y_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] rsp_result_o;
    logic [2:0]   rsp_op_o;
    logic         rsp_timeout_o;
    logic         busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, alu_y_i, rsp_ready_i,
        output req_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o,
               rsp_result_o, rsp_op_o, rsp_timeout_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, alu_y_i, rsp_ready_i,
        input  req_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o,
               rsp_result_o, rsp_op_o, rsp_timeout_o, busy_o
    );
endinterface

// File: rtl/td_alu_sequencer.sv
// Drives one op through a time-domain ALU and measures the returned edge timing.
// Latency: response valid SETUP_CYC + 2^W + 2 cycles after the accepting edge.
// Backpressure: one request in flight; result held until rsp_ready_i, no queuing.
module td_alu_sequencer #(
    parameter int W         = 4,
    parameter int SETUP_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    td_alu_sequencer_if.slave bus
);
    localparam int CW = ((W + 1) > $clog2(SETUP_CYC + 1)) ? (W + 1) : $clog2(SETUP_CYC + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] FIRE_LAST  = CW'((2 ** W) + 1);
    localparam logic [CW-1:0] EVAL_START = CW'(2);

    typedef enum logic [1:0] {IDLE, SETUP, FIRE, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          y_m, y_s;
    logic [W-1:0]  a_q, b_q;
    logic [2:0]    op_q;
    logic          alu_a, alu_b;
    logic          found;
    logic [W-1:0]  result;
    logic          timeout;
    logic [W-1:0]  t_evt;
    logic          eval, last, first_hit, width_hit, timeout_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        accept          = 1'b0;
        bus.req_ready_o = (state == IDLE) && !rst_i;
        bus.busy_o      = (state != IDLE);
        bus.rsp_valid_o = (state == RESP);
        case (state)
            IDLE: begin
                if (bus.req_valid_i && !rst_i) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = FIRE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            FIRE: begin
                if (cnt == FIRE_LAST) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // y_s lags the ALU by two cycles, so the event time is cnt - 2
    always_comb begin
        t_evt       = W'(cnt - EVAL_START);
        eval        = (state == FIRE) && (cnt >= EVAL_START);
        last        = (state == FIRE) && (cnt == FIRE_LAST);
        first_hit   = 1'b0;
        width_hit   = 1'b0;
        timeout_nxt = 1'b0;
        case (op_q)
            3'd0, 3'd1, 3'd4, 3'd5: begin
                first_hit   = eval && !found && y_s;
                timeout_nxt = !(found || first_hit);
            end
            3'd2: begin
                first_hit   = eval && !found && !y_s;
                timeout_nxt = !(found || first_hit);
            end
            3'd3:    width_hit   = eval && y_s;
            default: timeout_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_m     <= 1'b0;
            y_s     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            alu_a   <= 1'b0;
            alu_b   <= 1'b0;
            found   <= 1'b0;
            result  <= '0;
            timeout <= 1'b0;
        end else begin
            y_m   <= bus.alu_y_i;
            y_s   <= y_m;
            // edges are registered against the count of the cycle they appear in
            alu_a <= (state_nxt == FIRE) && (cnt_nxt >= CW'(a_q));
            alu_b <= (state_nxt == FIRE) && (cnt_nxt >= CW'(b_q));
            if (accept) begin
                a_q     <= bus.req_a_i;
                b_q     <= bus.req_b_i;
                op_q    <= bus.req_op_i;
                found   <= 1'b0;
                result  <= '0;
                timeout <= 1'b0;
            end
            if (first_hit) begin
                found  <= 1'b1;
                result <= t_evt;
            end
            if (width_hit && (result != {W{1'b1}})) result <= result + W'(1);
            if (last) timeout <= timeout_nxt;
        end
    end

    assign bus.alu_a_o       = alu_a;
    assign bus.alu_b_o       = alu_b;
    assign bus.alu_op_o      = op_q;
    assign bus.rsp_op_o      = op_q;
    assign bus.rsp_result_o  = result;
    assign bus.rsp_timeout_o = timeout;
endmodule

// File: tb/tb_td_alu_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random ops.
module tb_td_alu_sequencer;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_y;
    int   checks = 0;
    int   errors = 0;

    td_alu_sequencer_if #(.W(4)) bus ();

    td_alu_sequencer #(.W(4), .SETUP_CYC(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural time-domain ALU: a rising edge marks the operand's arrival time
    always_comb begin
        case (bus.alu_op_o)
            3'd0:    alu_y = bus.alu_a_o & bus.alu_b_o;
            3'd1:    alu_y = bus.alu_a_o | bus.alu_b_o;
            3'd2:    alu_y = ~(bus.alu_a_o ^ bus.alu_b_o);
            3'd3:    alu_y = bus.alu_a_o ^ bus.alu_b_o;
            3'd4:    alu_y = bus.alu_a_o;
            3'd5:    alu_y = bus.alu_b_o;
            default: alu_y = 1'b0;
        endcase
    end
    assign bus.alu_y_i = alu_y;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_res;
        logic       exp_to;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_model(input int op, input int a, input int b,
                                      output int res, output int to);
        res = 0;
        to  = 0;
        case (op)
            0: res = (a > b) ? a : b;
            1: res = (a < b) ? a : b;
            2: if (a == b) to = 1; else res = (a < b) ? a : b;
            3: res = (a > b) ? a - b : b - a;
            4: res = a;
            5: res = b;
            default: to = 1;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", int'(bus.req_ready_o), 1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("post_hs_valid", int'(bus.rsp_valid_o), 0);
        check("post_hs_ready", int'(bus.req_ready_o), 1);
    endtask

    task automatic run_txn(input string name, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input int exp_res, input int exp_to,
                           input int stall);
        int lat;
        send(op, a, b);
        wait_rsp(lat);
        check({name, "_latency"}, lat, LAT);
        check({name, "_result"}, int'(bus.rsp_result_o), exp_res);
        check({name, "_timeout"}, int'(bus.rsp_timeout_o), exp_to);
        check({name, "_op"}, int'(bus.rsp_op_o), int'(op));
        for (int i = 0; i < stall; i++) @(negedge clk);
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[13];
        int   lat, res, to, held_res, held_to, held_op, seen;

        vecs[0]  = '{3'd0, 4'd3,  4'd9,  4'd9,  1'b0};
        vecs[1]  = '{3'd1, 4'd12, 4'd5,  4'd5,  1'b0};
        vecs[2]  = '{3'd3, 4'd2,  4'd11, 4'd9,  1'b0};
        vecs[3]  = '{3'd3, 4'd7,  4'd7,  4'd0,  1'b0};
        vecs[4]  = '{3'd4, 4'd15, 4'd0,  4'd15, 1'b0};
        vecs[5]  = '{3'd2, 4'd0,  4'd6,  4'd0,  1'b0};
        vecs[6]  = '{3'd2, 4'd8,  4'd4,  4'd4,  1'b0};
        vecs[7]  = '{3'd6, 4'd10, 4'd3,  4'd0,  1'b1};
        vecs[8]  = '{3'd5, 4'd1,  4'd13, 4'd13, 1'b0};
        vecs[9]  = '{3'd2, 4'd5,  4'd5,  4'd0,  1'b1};
        vecs[10] = '{3'd7, 4'd0,  4'd15, 4'd0,  1'b1};
        vecs[11] = '{3'd3, 4'd15, 4'd0,  4'd15, 1'b0};
        vecs[12] = '{3'd0, 4'd0,  4'd0,  4'd0,  1'b0};

        bus.req_valid_i = 1'b0;
        bus.req_op_i    = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.rsp_ready_i = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(bus.req_ready_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_valid", int'(bus.rsp_valid_o), 0);
        check("rst_alu_a", int'(bus.alu_a_o), 0);
        check("rst_alu_b", int'(bus.alu_b_o), 0);
        check("rst_alu_op", int'(bus.alu_op_o), 0);
        check("rst_result", int'(bus.rsp_result_o), 0);
        check("rst_timeout", int'(bus.rsp_timeout_o), 0);
        check("rst_rsp_op", int'(bus.rsp_op_o), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(bus.req_ready_o), 1);
        @(negedge clk);

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    int'(vecs[i].exp_res), int'(vecs[i].exp_to), 0);

        // backpressure: result held 5 cycles; a request pending meanwhile is ignored
        send(3'd0, 4'd3, 4'd9);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd1;
        bus.req_a_i     = 4'd12;
        bus.req_b_i     = 4'd5;
        wait_rsp(lat);
        check("hold_latency", lat, LAT);
        held_res = int'(bus.rsp_result_o);
        held_to  = int'(bus.rsp_timeout_o);
        held_op  = int'(bus.rsp_op_o);
        check("hold_result", held_res, 9);
        check("hold_op", held_op, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", int'(bus.rsp_valid_o), 1);
            check("hold_ready", int'(bus.req_ready_o), 0);
            check("hold_result_stable", int'(bus.rsp_result_o), held_res);
            check("hold_timeout_stable", int'(bus.rsp_timeout_o), held_to);
            check("hold_op_stable", int'(bus.rsp_op_o), held_op);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("hs_ready_next", int'(bus.req_ready_o), 1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("next_accepted_busy", int'(bus.busy_o), 1);
        wait_rsp(lat);
        check("next_latency", lat, LAT);
        check("next_result", int'(bus.rsp_result_o), 5);
        check("next_op", int'(bus.rsp_op_o), 1);
        handshake();

        // reset in the middle of FIRE at cnt=5
        send(3'd0, 4'd3, 4'd9);
        repeat (7) @(negedge clk);
        check("mid_alu_a", int'(bus.alu_a_o), 1);
        check("mid_busy", int'(bus.busy_o), 1);
        rst = 1'b1;
        #1;
        check("abort_alu_a", int'(bus.alu_a_o), 0);
        check("abort_alu_b", int'(bus.alu_b_o), 0);
        check("abort_busy", int'(bus.busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", int'(bus.req_ready_o), 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) seen = 1;
        end
        check("abort_no_rsp", seen, 0);
        run_txn("after_abort", 3'd1, 4'd12, 4'd5, 5, 0, 0);

        // random ops against the closed-form reference
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [3:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            ref_model(int'(op), int'(a), int'(b), res, to);
            run_txn($sformatf("rand%0d", i), op, a, b, res, to, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
